// File: rtl/wb_gpio.sv
// Wishbone GPIO: direction-controlled outputs, synchronised inputs,
// per-pin edge capture into sticky status with a level interrupt.
module wb_gpio #(
   parameter int WIDTH       = 32,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             wb_cyc_i,
   input  logic             wb_stb_i,
   input  logic             wb_we_i,
   input  logic [31:0]      wb_adr_i,
   input  logic [31:0]      wb_dat_i,
   input  logic [3:0]       wb_sel_i,
   output logic [31:0]      wb_dat_o,
   output logic             wb_ack_o,
   output logic             wb_err_o,
   output logic             wb_stall_o,
   input  logic [WIDTH-1:0] gpio_i,
   output logic [WIDTH-1:0] gpio_o,
   output logic [WIDTH-1:0] gpio_oe_o,
   output logic             irq_o
);

   localparam logic [3:0] A_OUT = 4'd0;
   localparam logic [3:0] A_DIR = 4'd1;
   localparam logic [3:0] A_IN  = 4'd2;
   localparam logic [3:0] A_IE  = 4'd3;
   localparam logic [3:0] A_RIS = 4'd4;
   localparam logic [3:0] A_FAL = 4'd5;
   localparam logic [3:0] A_STS = 4'd6;
   localparam logic [3:0] A_SET = 4'd7;
   localparam logic [3:0] A_CLR = 4'd8;

   logic [WIDTH-1:0] out_q, dir_q, ie_q;
   logic [WIDTH-1:0] rise_q, fall_q, st_q, prev_q;
   logic [WIDTH-1:0] sync_q [SYNC_STAGES];
   logic             ack_q, err_q;
   logic [31:0]      dat_q;

   logic             req, wr, mapped;
   logic [3:0]       word;
   logic [31:0]      bmask, rdata;
   logic [WIDTH-1:0] wmask, wdat, w1c, out_n;
   logic [WIDTH-1:0] sync_w, rise_w, fall_w;
   logic             unused_ok;

   function automatic logic [WIDTH-1:0] merge(
      input logic [WIDTH-1:0] old,
      input logic [WIDTH-1:0] msk,
      input logic [WIDTH-1:0] val
   );
      return (old & ~msk) | val;
   endfunction

   assign word   = wb_adr_i[5:2];
   assign req    = wb_cyc_i & wb_stb_i;
   assign mapped = (word < 4'd9);
   assign wr     = req & wb_we_i & mapped;

   assign bmask = {{8{wb_sel_i[3]}}, {8{wb_sel_i[2]}},
                   {8{wb_sel_i[1]}}, {8{wb_sel_i[0]}}};
   assign wmask = bmask[WIDTH-1:0];
   assign wdat  = wb_dat_i[WIDTH-1:0] & wmask;

   assign sync_w = sync_q[SYNC_STAGES-1];
   assign rise_w = sync_w & ~prev_q;
   assign fall_w = ~sync_w & prev_q;

   assign unused_ok = ^{wb_adr_i[31:6], wb_adr_i[1:0],
                        bmask, wb_dat_i};

   always_comb begin
      out_n = out_q;
      if (wr) begin
         case (word)
            A_OUT:   out_n = merge(out_q, wmask, wdat);
            A_SET:   out_n = out_q | wdat;
            A_CLR:   out_n = out_q & ~wdat;
            default: out_n = out_q;
         endcase
      end
   end

   assign w1c = (wr && word == A_STS) ? wdat : '0;

   always_comb begin
      rdata = '0;
      case (word)
         A_OUT:   rdata[WIDTH-1:0] = out_q;
         A_DIR:   rdata[WIDTH-1:0] = dir_q;
         A_IN:    rdata[WIDTH-1:0] = sync_w;
         A_IE:    rdata[WIDTH-1:0] = ie_q;
         A_RIS:   rdata[WIDTH-1:0] = rise_q;
         A_FAL:   rdata[WIDTH-1:0] = fall_q;
         A_STS:   rdata[WIDTH-1:0] = st_q;
         default: rdata = '0;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         for (int i = 0; i < SYNC_STAGES; i++)
            sync_q[i] <= '0;
         prev_q <= '0;
         out_q  <= '0;
         dir_q  <= '0;
         ie_q   <= '0;
         rise_q <= '0;
         fall_q <= '0;
         st_q   <= '0;
         ack_q  <= 1'b0;
         err_q  <= 1'b0;
         dat_q  <= '0;
      end else begin
         sync_q[0] <= gpio_i;
         for (int i = 1; i < SYNC_STAGES; i++)
            sync_q[i] <= sync_q[i-1];
         prev_q <= sync_w;
         out_q  <= out_n;
         if (wr) begin
            case (word)
               A_DIR:   dir_q  <= merge(dir_q, wmask, wdat);
               A_IE:    ie_q   <= merge(ie_q, wmask, wdat);
               A_RIS:   rise_q <= merge(rise_q, wmask, wdat);
               A_FAL:   fall_q <= merge(fall_q, wmask, wdat);
               default: ;
            endcase
         end
         // Clear before set so an edge in the W1C cycle survives.
         st_q  <= (st_q & ~w1c) | (rise_w & rise_q)
                | (fall_w & fall_q);
         ack_q <= req & mapped;
         err_q <= req & ~mapped;
         if (req)
            dat_q <= wb_we_i ? 32'd0 : rdata;
      end
   end

   assign wb_dat_o   = dat_q;
   assign wb_ack_o   = ack_q & wb_cyc_i;
   assign wb_err_o   = err_q & wb_cyc_i;
   assign wb_stall_o = 1'b0;
   assign gpio_o     = out_q;
   assign gpio_oe_o  = dir_q;
   assign irq_o      = |(st_q & ie_q);

endmodule

// File: tb/tb_wb_gpio.sv
// Bench for wb_gpio: vector table, directed edge/abort/throughput
// sequences and a randomized run against a register-level model.
module tb_wb_gpio;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
   logic [31:0] adr = '0, wdat = '0;
   logic [3:0]  sel = '0;
   logic [31:0] rdat;
   logic        ack, err, stall, irq;
   logic [31:0] pad = 32'hFFFF_FFFF;
   logic [31:0] gpo, gpoe;

   int n_cmp = 0;
   int n_fail = 0;

   logic [31:0] m_out = 0, m_dir = 0, m_ie = 0;
   logic [31:0] m_rise = 0, m_fall = 0, m_st = 0, m_pad = 0;

   wb_gpio #(.WIDTH(32), .SYNC_STAGES(2)) dut (
      .clk_i(clk), .rst_i(rst),
      .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we),
      .wb_adr_i(adr), .wb_dat_i(wdat), .wb_sel_i(sel),
      .wb_dat_o(rdat), .wb_ack_o(ack), .wb_err_o(err),
      .wb_stall_o(stall),
      .gpio_i(pad), .gpio_o(gpo), .gpio_oe_o(gpoe),
      .irq_o(irq)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1, "timeout");
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   function automatic logic [31:0] lanes(input logic [3:0] s);
      logic [31:0] m;
      for (int b = 0; b < 4; b++)
         m[b*8 +: 8] = s[b] ? 8'hFF : 8'h00;
      return m;
   endfunction

   function automatic logic [31:0] mrd(input logic [3:0] w);
      case (w)
         4'd0: return m_out;
         4'd1: return m_dir;
         4'd2: return m_pad;
         4'd3: return m_ie;
         4'd4: return m_rise;
         4'd5: return m_fall;
         4'd6: return m_st;
         default: return 32'd0;
      endcase
   endfunction

   task automatic mwr(input logic [3:0] w, input logic [31:0] d,
                      input logic [3:0] s);
      logic [31:0] m, v;
      m = lanes(s);
      v = d & m;
      case (w)
         4'd0: m_out  = (m_out & ~m) | v;
         4'd1: m_dir  = (m_dir & ~m) | v;
         4'd3: m_ie   = (m_ie & ~m) | v;
         4'd4: m_rise = (m_rise & ~m) | v;
         4'd5: m_fall = (m_fall & ~m) | v;
         4'd6: m_st   = m_st & ~v;
         4'd7: m_out  = m_out | v;
         4'd8: m_out  = m_out & ~v;
         default: ;
      endcase
   endtask

   task automatic present(input logic w, input logic [3:0] a,
                          input logic [31:0] d, input logic [3:0] s);
      cyc = 1'b1; stb = 1'b1; we = w;
      adr = 32'h0200_0000 | {26'd0, a, 2'b00};
      wdat = d; sel = s;
      if (w && a < 4'd9) mwr(a, d, s);
   endtask

   task automatic idle_bus();
      cyc = 1'b0; stb = 1'b0; we = 1'b0;
   endtask

   task automatic access(input logic w, input logic [3:0] a,
                         input logic [31:0] d, input logic [3:0] s,
                         output logic [31:0] rd, output logic ak,
                         output logic er);
      @(negedge clk);
      present(w, a, d, s);
      @(negedge clk);
      rd = rdat; ak = ack; er = err;
      idle_bus();
   endtask

   task automatic pad_set(input logic [31:0] v);
      @(negedge clk);
      pad = v;
      repeat (4) @(negedge clk);
      m_st = m_st | (v & ~m_pad & m_rise) | (~v & m_pad & m_fall);
      m_pad = v;
   endtask

   typedef struct {
      logic        w;
      logic [3:0]  a;
      logic [31:0] d;
      logic [3:0]  s;
      logic        crd;
      logic [31:0] rd;
      logic        ak;
      logic        er;
   } vec_t;

   vec_t tbl[$];

   initial begin
      logic [31:0] r;
      logic ak, er;

      tbl.push_back('{1, 0, 32'hA5A5A5A5, 4'hF, 0, 0, 1, 0});
      tbl.push_back('{1, 0, 32'h12345678, 4'h2, 0, 0, 1, 0});
      tbl.push_back('{0, 0, 0, 4'hF, 1, 32'hA5A556A5, 1, 0});
      tbl.push_back('{1, 7, 32'h0000000F, 4'hF, 0, 0, 1, 0});
      tbl.push_back('{1, 8, 32'h00000005, 4'hF, 0, 0, 1, 0});
      tbl.push_back('{0, 0, 0, 4'hF, 1, 32'hA5A556AA, 1, 0});
      tbl.push_back('{0, 7, 0, 4'hF, 1, 32'h0, 1, 0});
      tbl.push_back('{0, 8, 0, 4'hF, 1, 32'h0, 1, 0});
      tbl.push_back('{0, 10, 0, 4'hF, 1, 32'h0, 0, 1});
      tbl.push_back('{1, 12, 32'hFFFFFFFF, 4'hF, 0, 0, 0, 1});
      tbl.push_back('{0, 0, 0, 4'hF, 1, 32'hA5A556AA, 1, 0});
      tbl.push_back('{1, 2, 32'h0000FFFF, 4'hF, 0, 0, 1, 0});
      tbl.push_back('{0, 2, 0, 4'hF, 1, 32'hFFFFFFFF, 1, 0});
      tbl.push_back('{1, 1, 32'h0000FFFF, 4'h1, 0, 0, 1, 0});
      tbl.push_back('{0, 1, 0, 4'hF, 1, 32'h000000FF, 1, 0});
      tbl.push_back('{0, 6, 0, 4'hF, 1, 32'h0, 1, 0});

      repeat (3) @(negedge clk);
      chk("rst_gpio_o", gpo, 0);
      chk("rst_gpio_oe", gpoe, 0);
      chk("rst_irq", irq, 0);
      chk("rst_ack_err", {ack, err, stall}, 0);
      chk("rst_dat", rdat, 0);
      rst = 1'b1;
      m_pad = pad;

      foreach (tbl[i]) begin
         access(tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].s, r, ak, er);
         chk($sformatf("vec%0d_ack", i), ak, tbl[i].ak);
         chk($sformatf("vec%0d_err", i), er, tbl[i].er);
         if (tbl[i].crd)
            chk($sformatf("vec%0d_dat", i), r, tbl[i].rd);
         chk($sformatf("vec%0d_gpio_o", i), gpo, m_out);
      end

      pad_set(32'h0);
      access(1, 3, 32'h1, 4'hF, r, ak, er);
      access(1, 4, 32'h1, 4'hF, r, ak, er);
      @(negedge clk) pad[0] = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("edge_irq_early", irq, 0);
      @(negedge clk);
      chk("edge_irq_set", irq, 1);
      m_st = 32'h1; m_pad = 32'h1;
      access(0, 6, 0, 4'hF, r, ak, er);
      chk("edge_status", r, 32'h1);
      access(1, 6, 32'h1, 4'hF, r, ak, er);
      chk("w1c_irq_drop", irq, 0);
      pad_set(32'h0);
      access(0, 6, 0, 4'hF, r, ak, er);
      chk("fall_ignored", r, 32'h0);

      access(1, 4, 32'h9, 4'hF, r, ak, er);
      @(negedge clk) pad[3] = 1'b1;
      @(negedge clk);
      access(1, 6, 32'h8, 4'hF, r, ak, er);
      m_st = m_st | 32'h8; m_pad = 32'h8;
      access(0, 6, 0, 4'hF, r, ak, er);
      chk("set_wins", r, 32'h8);

      @(negedge clk);
      present(1, 1, 32'h55, 4'hF);
      @(negedge clk);
      idle_bus();
      #1 chk("abort_no_ack", {ack, err}, 0);
      access(0, 1, 0, 4'hF, r, ak, er);
      chk("abort_committed", r, 32'h55);

      @(negedge clk);
      present(1, 0, 32'hCAFEF00D, 4'hF);
      @(negedge clk);
      chk("tp0_ack", ack, 1);
      present(0, 0, 0, 4'hF);
      @(negedge clk);
      chk("tp1_ack", ack, 1);
      chk("tp1_dat", rdat, 32'hCAFEF00D);
      present(0, 2, 0, 4'hF);
      @(negedge clk);
      chk("tp2_ack", ack, 1);
      chk("tp2_dat", rdat, m_pad);
      present(0, 1, 0, 4'hF);
      @(negedge clk);
      chk("tp3_ack", ack, 1);
      chk("tp3_dat", rdat, 32'h55);
      idle_bus();

      access(1, 6, 32'hFFFFFFFF, 4'hF, r, ak, er);
      for (int k = 0; k < 200; k++) begin
         int op;
         logic [3:0] a;
         logic w;
         logic [31:0] d, e;
         logic [3:0] s;
         op = $urandom_range(0, 11);
         d = $urandom;
         s = 4'($urandom);
         w = 1'($urandom);
         if (op == 11) begin
            pad_set($urandom);
         end else begin
            if (op == 10) a = 4'($urandom_range(9, 15));
            else a = 4'(op);
            e = mrd(a);
            access(w, a, d, s, r, ak, er);
            chk($sformatf("rnd%0d_ack", k), ak, a < 4'd9);
            chk($sformatf("rnd%0d_err", k), er, a >= 4'd9);
            if (!w)
               chk($sformatf("rnd%0d_dat", k), r, e);
         end
         chk($sformatf("rnd%0d_out", k), gpo, m_out);
         chk($sformatf("rnd%0d_oe", k), gpoe, m_dir);
         chk($sformatf("rnd%0d_irq", k), irq, |(m_st & m_ie));
      end

      @(negedge clk);
      present(0, 0, 0, 4'hF);
      @(posedge clk);
      #1 chk("rst_mid_pre", ack, 1);
      rst = 1'b0;
      #1 chk("rst_mid_ack", ack, 0);
      chk("rst_mid_out", gpo, 0);
      @(negedge clk);
      idle_bus();
      rst = 1'b1;
      @(negedge clk);
      chk("rst_after_ack", ack, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/wb_gpio.md
# wb_gpio

General-purpose I/O peripheral on the SoC Wishbone bus, occupying the GPIOA crossbar slot at 0x02000000 (64-byte window). It provides direction-controlled output pins, double-flop synchronised inputs, and per-pin rising/falling-edge interrupt capture with a sticky status register. A single level interrupt is routed to the picorv32 `irq` vector. All logic runs in the Wishbone clock domain.

## Interface
- `WIDTH`, 32 — number of GPIO pins, 1..32. Register bits at WIDTH and above read 0 and ignore writes.
- `SYNC_STAGES`, 2 — input synchroniser depth, 2..4.

Ports:
- `clk_i`  in  1  Wishbone clock. One clock only.
- `rst_i`  in  1  Reset, asynchronous, active-low. All state is cleared while it is low.
- `wb_cyc_i`  in  1  Bus cycle.
- `wb_stb_i`  in  1  Strobe.
- `wb_we_i`  in  1  Write enable.
- `wb_adr_i`  in  32  Byte address. Only [5:2] is decoded.
- `wb_dat_i`  in  32  Write data.
- `wb_sel_i`  in  4  Byte lane enables.
- `wb_dat_o`  out  32  Read data, registered.
- `wb_ack_o`  out  1  Acknowledge.
- `wb_err_o`  out  1  Error, asserted for unmapped word addresses.
- `wb_stall_o`  out  1  Tied to 0.
- `gpio_i`  in  WIDTH  Pad inputs, asynchronous.
- `gpio_o`  out  WIDTH  Output data.
- `gpio_oe_o`  out  WIDTH  Output enable, 1 = drive.
- `irq_o`  out  1  Level interrupt.

## Operation
Register map, indexed by word address `wb_adr_i[5:2]`:
- 0 OUT (RW): output latch. `gpio_o = OUT`.
- 1 DIR (RW): direction. `gpio_oe_o = DIR`.
- 2 IN (RO): synchronised `gpio_i`. Writes are acked and ignored.
- 3 IE (RW): per-pin interrupt enable.
- 4 RISE (RW): capture rising edges.
- 5 FALL (RW): capture falling edges.
- 6 STATUS (R/W1C): sticky edge flags.
- 7 SET (WO): `OUT |= data`. Reads return 0.
- 8 CLR (WO): `OUT &= ~data`. Reads return 0.
- 9..15: unmapped. The access returns `wb_err_o` instead of ack, has no side effect, and read data is 0.

Rules:
- A request is accepted when `wb_cyc_i & wb_stb_i` is high. There is no stall, so one request can be accepted per cycle.
- Byte lanes: each written byte updates only where the matching `wb_sel_i` bit is 1. This applies to OUT, DIR, IE, RISE, FALL, SET, CLR and the STATUS W1C mask.
- Synchroniser: `SYNC_STAGES` flops, then one extra `prev` register.
  - `rise = sync & ~prev`.
  - `fall = ~sync & prev`.
- Status update, per bit: `STATUS_next = (STATUS & ~w1c_mask) | (rise & RISE) | (fall & FALL)`.
  - A new edge in the same cycle as a W1C of that bit leaves the bit set (set wins).
  - Edges are captured regardless of IE.
- `irq_o = |(STATUS & IE)`, combinational from registers.
- Reset values: OUT, DIR, IE, RISE, FALL and STATUS are 0; synchroniser and `prev` are 0; `wb_dat_o`, `wb_ack_o` and `wb_err_o` are 0. Consequently `gpio_o`, `gpio_oe_o` and `irq_o` are 0 in reset.
- After reset deasserts, an input already high produces one rising edge once it propagates through the synchroniser. Software clears STATUS after enabling.

## Timing
- Writes take effect on the accepting clock edge.
  - `gpio_o` / `gpio_oe_o` change in the cycle after acceptance.
  - `irq_o` follows IE/STATUS in that same cycle.
- Ack/err are registered and asserted exactly the cycle after acceptance, for one cycle per request.
  - Back-to-back requests produce back-to-back acks.
- Abort: `wb_ack_o = ack_q & wb_cyc_i`, and likewise for err, so dropping `wb_cyc_i` suppresses a pending ack.
  - The write has already been committed at acceptance.
- Read data is sampled at the accepting edge and valid in the ack cycle.
  - A STATUS read in the same cycle as a new edge returns the pre-edge value.
- Input-to-status latency: a pad transition is set in STATUS `SYNC_STAGES+1` edges later.
  - `irq_o` rises in the same cycle STATUS is set.
- Pulses shorter than one clock period may be lost. This is acceptable.
- An asynchronous reset asserted mid-transaction clears ack immediately. No ack follows for the request in flight.

## Test plan
- **Reset/idle:** hold `rst_i`=0 with `gpio_i`=0xFFFFFFFF. All outputs read 0, `irq_o`=0. Release reset: STATUS reads 0 unless RISE is set.
- **Byte lanes:** write OUT=0xA5A5A5A5 with sel=0xF, then 0x12345678 with sel=0x2. Read gives 0xA5A556A5 and `gpio_o` matches. SET 0x0000000F then CLR 0x00000005 gives OUT=0xA5A556AA.
- **Edge IRQ:** IE=RISE=0x1, toggle `gpio_i[0]` 0→1. STATUS=0x1 and `irq_o`=1 three cycles later (SYNC_STAGES=2). W1C 0x1 drops `irq_o` the next cycle. FALL=0 means 1→0 sets nothing.
- **Set-wins collision:** schedule a rising edge on bit 3 to land on the same cycle as a W1C 0x8. STATUS bit 3 remains 1.
- **Unmapped/abort:** a read at 0x02000028 asserts `wb_err_o`, not ack, with dat 0. A write whose cyc drops the cycle after the strobe gives no ack, but the register is updated.
- **Throughput:** four consecutive strobes (W OUT, R OUT, R IN, R DIR) give four consecutive acks. Data is correct per beat, with the second beat returning the new OUT.
